load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the CPU execute stage and the `Cache` request port. It accepts one byte/half/word load or store per handshake and produces the cache `address`, `data_in` and `write_enable` byte mask. It sign- or zero-extends load results. Accesses that straddle a 32-bit word boundary are split into two cache accesses and merged.

## Interface
- `ADDRESS_BITWIDTH`, 32: byte address width on both sides.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  request present.
- `cmd_ready`  out  1  request accepted when `cmd_valid && cmd_ready`.
- `cmd_store`  in  1  0 load, 1 store.
- `cmd_size`  in  2  0 byte, 1 half, 2 word, 3 reserved.
- `cmd_signed`  in  1  load sign-extends when 1.
- `cmd_addr`  in  ADDRESS_BITWIDTH  byte address; any alignment.
- `cmd_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle pulse: request complete.
- `rsp_data`  out  32  load result, valid with `rsp_valid`; 0 for stores.
- `rsp_error`  out  1  reserved size; valid with `rsp_valid`.
- `address`  out  ADDRESS_BITWIDTH  to cache; always word-aligned.
- `data_in`  out  32  to cache.
- `write_enable`  out  4  byte mask to cache; 0 means read.
- `data_out`  in  32  from cache.
- `data_out_ready`  in  1  from cache.
- `busy`  in  1  from cache.

## Operation
- Offset `o = cmd_addr[1:0]`; byte count `n` is 1, 2 or 4.
- An access is split when `o + n > 4`: words at o≠0, halves at o=3.
- Access 0 targets `{addr[..:2],00}`.
- Access 1 targets access 0 + 4, modulo 2^ADDRESS_BITWIDTH (0xFFFFFFFC wraps to 0).
- Store masks:
  - access 0 mask is lanes o..min(o+n,4)-1, data `wdata << 8*o`;
  - access 1 mask is lanes 0..o+n-5, data `wdata >> 8*(4-o)`.
- Load merge: form `{word1,word0} >> 8*o` and keep n bytes. Extend from bit 8n-1 when `cmd_signed`, else zero-fill. word1 is 0 if not split.
- Reserved size: no cache access; `rsp_valid` with `rsp_error=1` and `rsp_data=0` the cycle after acceptance.
- Request fields are latched on acceptance. Later input changes are ignored.
- States:
  - IDLE: `cmd_ready=1`. Accept goes to ISSUE0, or to RESP for reserved size.
  - ISSUE0: drive access 0. In the first cycle with `busy==0`, a store goes to ISSUE1 if split, else RESP. A load goes to WAIT0.
  - WAIT0: `write_enable=0`, address held. On `data_out_ready && !busy`, latch word0 and go to ISSUE1 if split, else RESP.
  - ISSUE1 / WAIT1: same as ISSUE0 / WAIT0 for access 1; exits to RESP.
  - RESP: `rsp_valid=1` for one cycle, then IDLE.
- `write_enable` is nonzero only during the single ISSUE cycle that sees `busy==0`. It is 0 in all other states.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `rsp_valid=0`, `rsp_data=0`, `rsp_error=0`, `address=0`, `data_in=0`, `write_enable=0`.
- Reset mid-operation: outputs return to reset values immediately (asynchronous) and the in-flight request is dropped. A half-completed split store stays half-written.
- Minimum latency with `busy` low throughout, acceptance cycle T:
  - aligned store: write at T+1, `rsp_valid` T+2;
  - split store: writes at T+1 and T+2, `rsp_valid` T+3;
  - load: cache hit timing plus one cycle per access plus one cycle for RESP.
- `busy` high in ISSUE: hold address/data/mask with `write_enable` forced to 0 until `busy==0`.
- No new acceptance until RESP has completed; back-to-back requests are spaced by at least one IDLE cycle.
- `rsp_data` is registered and holds its value until the next RESP.

## Structure
- Package `lsu_pkg` holds:
  - size enum (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`, `SIZE_RSVD`);
  - state enum;
  - byte-count function;
  - lane-mask function.
- One combinational sub-module `lsu_load_align` (word0, word1, offset, size, signed → 32-bit result). It is reused by the verification reference model.
- The FSM, latches and store shifting stay in the top module.

## Test plan
- Aligned word store 0xDEADBEEF @0x10, then word load @0x10 → `write_enable=1111`, `address=0x10`; load `rsp_data=0xDEADBEEF`.
- Byte store 0x80 @0x13, signed byte load @0x13 → mask 1000, `data_in=0x80000000`; `rsp_data=0xFFFFFF80`; unsigned load returns 0x00000080.
- Split word store 0x11223344 @0x1E:
  - writes mask 1100 @0x1C with `data_in=0x33440000`, then mask 0011 @0x20 with `data_in=0x00001122`;
  - word load @0x1E → 0x11223344.
- Half load @0x...FFF (top of address space) → second access at `address=0`.
- `busy` held high 5 cycles during ISSUE0 → `write_enable` 0 throughout, one write only after release; `cmd_size=3` → `rsp_error=1`, no cache access.
- Assert `rst` between the two writes of a split store → outputs at reset values the same cycle, `cmd_ready=1`, no second write.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// byte counts and byte-lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StWait0,
    StIssue1,
    StWait1,
    StResp
  } state_e;

  function automatic logic [2:0] byte_count(size_e size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  // Lanes touched across two consecutive words: [3:0] is access 0, [7:4] is access 1.
  function automatic logic [7:0] lane_mask(logic [1:0] offset, size_e size);
    logic [7:0] base;
    base = 8'((9'd1 << byte_count(size)) - 9'd1);
    return base << offset;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Merges up to two cache words into a right-aligned, sign/zero-extended load result.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [31:0] merged;

  always_comb begin
    merged = 32'({word1, word0} >> {offset, 3'b000});
    case (size)
      SIZE_BYTE: result = {{24{is_signed & merged[7]}}, merged[7:0]};
      SIZE_HALF: result = {{16{is_signed & merged[15]}}, merged[15:0]};
      SIZE_WORD: result = merged;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-aligned cache accesses,
// splitting accesses that straddle a word boundary and merging split loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDRESS_BITWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_store,
  input  logic [1:0]                  cmd_size,
  input  logic                        cmd_signed,
  input  logic [ADDRESS_BITWIDTH-1:0] cmd_addr,
  input  logic [31:0]                 cmd_wdata,
  output logic                        rsp_valid,
  output logic [31:0]                 rsp_data,
  output logic                        rsp_error,
  output logic [ADDRESS_BITWIDTH-1:0] address,
  output logic [31:0]                 data_in,
  output logic [3:0]                  write_enable,
  input  logic [31:0]                 data_out,
  input  logic                        data_out_ready,
  input  logic                        busy
);

  localparam logic [ADDRESS_BITWIDTH-1:0] WordStride = ADDRESS_BITWIDTH'(4);

  state_e      state;
  logic        store_q, signed_q, split_q;
  size_e       size_q;
  logic [1:0]  offset_q;
  logic [3:0]  mask_q, mask1_q;
  logic [31:0] data1_q, word0_q;

  size_e       cmd_size_e;
  logic [7:0]  lanes;
  logic [63:0] shifted;
  logic [31:0] align_word0, align_word1, load_result;

  always_comb begin
    cmd_size_e  = size_e'(cmd_size);
    lanes       = lane_mask(cmd_addr[1:0], cmd_size_e);
    shifted     = {32'b0, cmd_wdata} << {cmd_addr[1:0], 3'b000};
    // The final word is taken straight from the cache in the cycle it arrives.
    align_word0 = (state == StWait0) ? data_out : word0_q;
    align_word1 = (state == StWait1) ? data_out : '0;
  end

  assign cmd_ready    = (state == StIdle);
  assign rsp_valid    = (state == StResp);
  assign write_enable = ((state == StIssue0 || state == StIssue1) && store_q && !busy) ?
                        mask_q : '0;

  lsu_load_align u_load_align (
    .word0     (align_word0),
    .word1     (align_word1),
    .offset    (offset_q),
    .size      (size_q),
    .is_signed (signed_q),
    .result    (load_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      store_q   <= 1'b0;
      signed_q  <= 1'b0;
      split_q   <= 1'b0;
      size_q    <= SIZE_BYTE;
      offset_q  <= '0;
      mask_q    <= '0;
      mask1_q   <= '0;
      data1_q   <= '0;
      word0_q   <= '0;
      address   <= '0;
      data_in   <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (cmd_valid) begin
            store_q  <= cmd_store;
            signed_q <= cmd_signed;
            size_q   <= cmd_size_e;
            offset_q <= cmd_addr[1:0];
            if (cmd_size_e == SIZE_RSVD) begin
              rsp_data  <= '0;
              rsp_error <= 1'b1;
              state     <= StResp;
            end else begin
              split_q <= |lanes[7:4];
              mask_q  <= lanes[3:0];
              mask1_q <= lanes[7:4];
              data_in <= shifted[31:0];
              data1_q <= shifted[63:32];
              address <= {cmd_addr[ADDRESS_BITWIDTH-1:2], 2'b00};
              state   <= StIssue0;
            end
          end
        end
        StIssue0: begin
          if (!busy) begin
            if (!store_q) begin
              state <= StWait0;
            end else if (split_q) begin
              address <= address + WordStride;
              data_in <= data1_q;
              mask_q  <= mask1_q;
              state   <= StIssue1;
            end else begin
              rsp_data  <= '0;
              rsp_error <= 1'b0;
              state     <= StResp;
            end
          end
        end
        StWait0: begin
          if (data_out_ready && !busy) begin
            word0_q <= data_out;
            if (split_q) begin
              address <= address + WordStride;
              data_in <= data1_q;
              mask_q  <= mask1_q;
              state   <= StIssue1;
            end else begin
              rsp_data  <= load_result;
              rsp_error <= 1'b0;
              state     <= StResp;
            end
          end
        end
        StIssue1: begin
          if (!busy) begin
            if (store_q) begin
              rsp_data  <= '0;
              rsp_error <= 1'b0;
              state     <= StResp;
            end else begin
              state <= StWait1;
            end
          end
        end
        StWait1: begin
          if (data_out_ready && !busy) begin
            rsp_data  <= load_result;
            rsp_error <= 1'b0;
            state     <= StResp;
          end
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array cache model and
// response/write scoreboards.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_store, cmd_signed;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_data;
  logic [31:0] address, data_in, data_out;
  logic [3:0]  write_enable;
  logic        data_out_ready, busy;

  logic [31:0] mem [64];

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign data_out = mem[address[7:2]];

  load_store_unit #(.ADDRESS_BITWIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_store      (cmd_store),
    .cmd_size       (cmd_size),
    .cmd_signed     (cmd_signed),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .address        (address),
    .data_in        (data_in),
    .write_enable   (write_enable),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.we   = we;
    w.data = d;
    wr_q.push_back(w);
  endtask

  // Called at a negedge with write_enable != 0: compare and update the cache model.
  task automatic observe_write(input string name);
    wr_t w;
    chk({name, " write_expected"}, 32'(wr_q.size() != 0), 32'd1);
    if (wr_q.size() != 0) begin
      w = wr_q.pop_front();
      chk({name, " wr_address"}, address, w.addr);
      chk({name, " wr_mask"}, 32'(write_enable), 32'(w.we));
      chk({name, " wr_data"}, data_in, w.data);
    end
    for (int b = 0; b < 4; b++)
      if (write_enable[b]) mem[address[7:2]][8*b +: 8] = data_in[8*b +: 8];
  endtask

  task automatic run_cmd(input string name, input logic st, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                         input int busy_cyc, input logic chk_addr, input logic [31:0] exp_addr);
    rsp_t r;
    bit   done;
    r.data = exp_data;
    r.err  = exp_err;
    rsp_q.push_back(r);
    chk({name, " ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_store  = st;
    cmd_size   = sz;
    cmd_signed = sg;
    cmd_addr   = a;
    cmd_wdata  = wd;
    @(posedge clk); #1;
    // Scramble the request fields: the DUT must work from its latched copy.
    cmd_valid  = 1'b0;
    cmd_store  = 1'($urandom);
    cmd_size   = 2'($urandom);
    cmd_signed = 1'($urandom);
    cmd_addr   = $urandom;
    cmd_wdata  = $urandom;
    done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      busy = (k <= busy_cyc);
      @(negedge clk);
      if (busy) chk({name, " we_while_busy"}, 32'(write_enable), 32'd0);
      if (write_enable != 4'b0) observe_write(name);
      if (rsp_valid) begin
        done = 1;
        chk({name, " rsp_queued"}, 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          chk({name, " rsp_data"}, rsp_data, r.data);
          chk({name, " rsp_error"}, 32'(rsp_error), 32'(r.err));
        end
        chk({name, " latency"}, 32'(k), 32'(exp_lat));
        if (chk_addr) chk({name, " last_address"}, address, exp_addr);
      end else begin
        chk({name, " ready_busy"}, 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    busy = 1'b0;
    chk({name, " rsp_seen"}, 32'(done), 32'd1);
    chk({name, " writes_done"}, 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    rsp_q.delete();
    @(negedge clk);
    chk({name, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({name, " ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, " rsp_data"}, rsp_data, 32'd0);
    chk({name, " rsp_error"}, 32'(rsp_error), 32'd0);
    chk({name, " address"}, address, 32'd0);
    chk({name, " data_in"}, data_in, 32'd0);
    chk({name, " write_enable"}, 32'(write_enable), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[63] = 32'hA1B2C3D4;
    mem[0]  = 32'h55667788;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_store = 1'b0; cmd_size = 2'd0; cmd_signed = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; data_out_ready = 1'b1; busy = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    exp_write(32'h10, 4'b1111, 32'hDEADBEEF);
    run_cmd("st_w_10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'h10);
    run_cmd("ld_w_10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0, 1, 32'h10);
    exp_write(32'h10, 4'b1000, 32'h80000000);
    run_cmd("st_b_13", 1, 2'd0, 0, 32'h13, 32'h80, 32'h0, 0, 2, 0, 1, 32'h10);
    run_cmd("ld_bs_13", 0, 2'd0, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0, 3, 0, 1, 32'h10);
    run_cmd("ld_bu_13", 0, 2'd0, 0, 32'h13, 32'h0, 32'h00000080, 0, 3, 0, 1, 32'h10);

    exp_write(32'h1C, 4'b1100, 32'h33440000);
    exp_write(32'h20, 4'b0011, 32'h00001122);
    run_cmd("st_w_1e", 1, 2'd2, 0, 32'h1E, 32'h11223344, 32'h0, 0, 3, 0, 1, 32'h20);
    run_cmd("ld_w_1e", 0, 2'd2, 0, 32'h1E, 32'h0, 32'h11223344, 0, 5, 0, 1, 32'h20);
    run_cmd("ld_hu_1e", 0, 2'd1, 0, 32'h1E, 32'h0, 32'h00003344, 0, 3, 0, 1, 32'h1C);
    exp_write(32'h20, 4'b1000, 32'hEF000000);
    exp_write(32'h24, 4'b0001, 32'h000000BE);
    run_cmd("st_h_23", 1, 2'd1, 0, 32'h23, 32'h0000BEEF, 32'h0, 0, 3, 0, 1, 32'h24);
    run_cmd("ld_hu_23", 0, 2'd1, 0, 32'h23, 32'h0, 32'h0000BEEF, 0, 5, 0, 1, 32'h24);
    run_cmd("ld_hs_top", 0, 2'd1, 1, 32'hFFFFFFFF, 32'h0, 32'hFFFF88A1, 0, 5, 0, 1, 32'h0);

    exp_write(32'h30, 4'b1111, 32'h0BADF00D);
    run_cmd("st_w_busy", 1, 2'd2, 0, 32'h30, 32'h0BADF00D, 32'h0, 0, 7, 5, 1, 32'h30);
    run_cmd("ld_w_busy", 0, 2'd2, 0, 32'h30, 32'h0, 32'h0BADF00D, 0, 5, 2, 1, 32'h30);
    run_cmd("ld_rsvd", 0, 2'd3, 1, 32'h40, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
    run_cmd("st_rsvd", 1, 2'd3, 0, 32'h44, 32'hFFFFFFFF, 32'h0, 1, 1, 0, 0, 32'h0);

    // Reset lands between the two halves of a split store.
    exp_write(32'h38, 4'b1110, 32'hFEF00D00);
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_size = 2'd2; cmd_signed = 1'b0;
    cmd_addr = 32'h39; cmd_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid first_write_seen", 32'(write_enable != 4'b0), 32'd1);
    if (write_enable != 4'b0) observe_write("rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid async");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid no_second_write", 32'(write_enable), 32'd0);
    end
    wr_q.delete();
    run_cmd("ld_w_38", 0, 2'd2, 0, 32'h38, 32'h0, 32'hFEF00D00, 0, 3, 0, 1, 32'h38);
    run_cmd("ld_w_3c", 0, 2'd2, 0, 32'h3C, 32'h0, 32'h00000000, 0, 3, 0, 1, 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
